// File: rtl/ima_adpcm_pkg.sv
// Shared definitions for the IMA ADPCM byte packer: FSM encodings, header
// geometry and the FIFO entry layout.
package ima_adpcm_pkg;

    typedef enum logic [2:0] {
        PK_IDLE,
        PK_HDR0,
        PK_HDR1,
        PK_HDR2,
        PK_HDR3,
        PK_DATA
    } pk_state_t;

    localparam int IMA_HDR_BYTES      = 4;
    localparam int IMA_MAX_STEP_INDEX = 88;

    typedef struct packed {
        logic       block_start;
        logic [7:0] data;
    } pk_entry_t;

endpackage

// File: rtl/adpcm_byte_fifo.sv
// First-word-fall-through FIFO with occupancy count. A push while full is
// accepted only when a pop happens in the same cycle.
module adpcm_byte_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ima_adpcm_pack.sv
// Packs 4-bit IMA ADPCM codes into header-prefixed byte blocks and buffers
// them in a small byte FIFO towards the consumer.
module ima_adpcm_pack
    import ima_adpcm_pkg::*;
#(
    parameter int CODES_PER_BLOCK = 504,
    parameter int FIFO_DEPTH      = 16,
    parameter int HOLD_FREE       = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  inPCM,
    input  logic        inPcmValid,
    input  logic [15:0] inPredictSamp,
    input  logic [6:0]  inStepIndex,
    output logic        holdOff,
    output logic [7:0]  outByte,
    output logic        outValid,
    input  logic        outReady,
    output logic        outBlockStart,
    output logic        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CODES_PER_BLOCK + 1);

    pk_state_t   state;
    pk_state_t   cur;
    logic [15:0] hdr_pred;
    logic [6:0]  hdr_idx;
    logic [15:0] snap_pred;
    logic [6:0]  snap_idx;
    logic [3:0]  held;
    logic [CW-1:0] cnt;

    pk_entry_t   wr_entry;
    pk_entry_t   rd_entry;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;
    logic [AW:0] count;
    logic [AW:0] free_slots;

    // Header byte 0 is pushed in the cycle the first code is accepted, so the
    // block's first byte reaches the consumer one cycle after that code.
    assign cur = (state == PK_IDLE && inPcmValid) ? PK_HDR0 : state;

    always_comb begin
        push     = 1'b0;
        wr_entry = '0;
        case (cur)
            PK_HDR0: begin push = 1'b1; wr_entry = '{1'b1, hdr_pred[7:0]};     end
            PK_HDR1: begin push = 1'b1; wr_entry = '{1'b0, snap_pred[15:8]};   end
            PK_HDR2: begin push = 1'b1; wr_entry = '{1'b0, {1'b0, snap_idx}};  end
            PK_HDR3: begin push = 1'b1; wr_entry = '{1'b0, 8'h00};             end
            PK_DATA: begin
                push     = inPcmValid && cnt[0];
                wr_entry = '{1'b0, {inPCM, held}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= PK_IDLE;
            hdr_pred  <= '0;
            hdr_idx   <= '0;
            snap_pred <= '0;
            snap_idx  <= '0;
            held      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
        end else begin
            if (inPcmValid) begin
                hdr_pred <= inPredictSamp;
                hdr_idx  <= inStepIndex;
            end
            if (push && full && !pop) overflow <= 1'b1;
            case (state)
                PK_IDLE: if (inPcmValid) begin
                    snap_pred <= hdr_pred;
                    snap_idx  <= hdr_idx;
                    held      <= inPCM;
                    cnt       <= CW'(1);
                    state     <= PK_HDR1;
                end
                PK_HDR0: state <= PK_HDR1;
                PK_HDR1: state <= PK_HDR2;
                PK_HDR2: state <= PK_HDR3;
                PK_HDR3: state <= PK_DATA;
                PK_DATA: if (inPcmValid) begin
                    if (!cnt[0]) held <= inPCM;
                    if (cnt == CW'(CODES_PER_BLOCK - 1)) begin
                        cnt   <= '0;
                        state <= PK_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= PK_IDLE;
            endcase
        end
    end

    assign pop = outValid && outReady;

    adpcm_byte_fifo #(
        .WIDTH(9),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .din  (wr_entry),
        .pop  (pop),
        .dout (rd_entry),
        .count(count),
        .full (full),
        .empty(empty)
    );

    assign outValid      = !empty;
    assign outByte       = empty ? 8'h00 : rd_entry.data;
    assign outBlockStart = !empty && rd_entry.block_start;
    assign free_slots    = (AW+1)'(FIFO_DEPTH) - count;
    assign holdOff       = free_slots < (AW+1)'(HOLD_FREE);

endmodule

// File: tb/tb_ima_adpcm_pack.sv
// Directed bench for ima_adpcm_pack with 4-code blocks and a 16-byte FIFO.
module tb_ima_adpcm_pack;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  inPCM;
    logic        inPcmValid;
    logic [15:0] inPredictSamp;
    logic [6:0]  inStepIndex;
    logic        holdOff;
    logic [7:0]  outByte;
    logic        outValid;
    logic        outReady;
    logic        outBlockStart;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    logic [8:0] cap [$];

    always #5 clock = ~clock;

    ima_adpcm_pack #(
        .CODES_PER_BLOCK(4),
        .FIFO_DEPTH     (16),
        .HOLD_FREE      (6)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .inPCM        (inPCM),
        .inPcmValid   (inPcmValid),
        .inPredictSamp(inPredictSamp),
        .inStepIndex  (inStepIndex),
        .holdOff      (holdOff),
        .outByte      (outByte),
        .outValid     (outValid),
        .outReady     (outReady),
        .outBlockStart(outBlockStart),
        .overflow     (overflow)
    );

    // Record every byte the consumer takes; the pop happens at the next rising edge.
    always @(negedge clock) begin
        if (!reset && outValid && outReady) cap.push_back({outBlockStart, outByte});
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at posedge+2; leaves the code valid for one cycle and keeps a 6-cycle gap.
    task automatic send_code(input logic [3:0] c, input logic [15:0] p, input logic [6:0] i);
        inPCM = c; inPredictSamp = p; inStepIndex = i; inPcmValid = 1'b1;
        @(posedge clock); #2;
        inPcmValid = 1'b0;
        repeat (5) begin @(posedge clock); #2; end
    endtask

    task automatic drain(output bit ok);
        outReady = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clock); #2;
            if (!outValid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; inPCM = '0; inPcmValid = 1'b0; inPredictSamp = '0;
        inStepIndex = '0; outReady = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({outValid, outByte, outBlockStart, holdOff, overflow} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b byte=%h bs=%b hold=%b ovf=%b, want all 0",
                     outValid, outByte, outBlockStart, holdOff, overflow);
        end
        @(posedge clock); #2;
        reset = 1'b0;
        cap.delete();
    endtask

    task automatic test_first_block;
        logic [8:0] exp_b [6] = '{9'h100, 9'h000, 9'h000, 9'h000, 9'h021, 9'h043};
        bit ok;
        outReady = 1'b1;
        inPCM = 4'h1; inPredictSamp = 16'h1234; inStepIndex = 7'd5; inPcmValid = 1'b1;
        @(negedge clock);
        checks++;
        if (outValid !== 1'b0) begin
            failures++; $display("FAIL latency_before: outValid=%b want 0", outValid);
        end
        @(posedge clock); #2;
        inPcmValid = 1'b0;
        @(negedge clock);
        checks++;
        if ({outValid, outBlockStart, outByte} !== 10'h300) begin
            failures++;
            $display("FAIL latency_hdr0: valid=%b bs=%b byte=%h want 1 1 00", outValid, outBlockStart, outByte);
        end
        repeat (4) begin @(posedge clock); #2; end
        send_code(4'h2, 16'h1234, 7'd5);
        send_code(4'h3, 16'h1234, 7'd5);
        send_code(4'h4, 16'h1234, 7'd5);
        drain(ok);
        checks++;
        if (!ok || cap.size() != 6) begin
            failures++; $display("FAIL first_block_len: got %0d bytes (drained=%0b) want 6", cap.size(), ok);
        end
        for (int k = 0; k < 6; k++) begin
            logic [8:0] got;
            got = (k < cap.size()) ? cap[k] : 9'hxxx;
            checks++;
            if (got !== exp_b[k]) begin
                failures++; $display("FAIL first_block[%0d]: got %h want %h", k, got, exp_b[k]);
            end
        end
        cap.delete();
    endtask

    task automatic test_back_to_back;
        logic [8:0] exp_b [12] = '{9'h134, 9'h012, 9'h005, 9'h000, 9'h065, 9'h087,
                                   9'h180, 9'h0FF, 9'h058, 9'h000, 9'h0A9, 9'h0CB};
        bit ok;
        outReady = 1'b1;
        send_code(4'h5, 16'h1234, 7'd5);
        send_code(4'h6, 16'h1234, 7'd5);
        send_code(4'h7, 16'h1234, 7'd5);
        send_code(4'h8, 16'hFF80, 7'd88);
        send_code(4'h9, 16'h0102, 7'd3);
        send_code(4'hA, 16'h0102, 7'd3);
        send_code(4'hB, 16'h0102, 7'd3);
        send_code(4'hC, 16'h0102, 7'd3);
        drain(ok);
        checks++;
        if (!ok || cap.size() != 12) begin
            failures++; $display("FAIL b2b_len: got %0d bytes (drained=%0b) want 12", cap.size(), ok);
        end
        for (int k = 0; k < 12; k++) begin
            logic [8:0] got;
            got = (k < cap.size()) ? cap[k] : 9'hxxx;
            checks++;
            if (got !== exp_b[k]) begin
                failures++; $display("FAIL b2b[%0d]: got %h want %h", k, got, exp_b[k]);
            end
        end
        cap.delete();
    endtask

    task automatic test_backpressure;
        logic [8:0] exp_b [12] = '{9'h102, 9'h001, 9'h003, 9'h000, 9'h021, 9'h043,
                                   9'h10B, 9'h00A, 9'h007, 9'h000, 9'h065, 9'h087};
        logic       exp_hold [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit ok;
        outReady = 1'b0;
        for (int k = 0; k < 7; k++) begin
            send_code(4'(k + 1), 16'h0A0B, 7'd7);
            @(negedge clock);
            checks++;
            if (holdOff !== exp_hold[k]) begin
                failures++; $display("FAIL holdoff_after_code%0d: got %b want %b", k + 1, holdOff, exp_hold[k]);
            end
            checks++;
            if ({outValid, outBlockStart, outByte} !== 10'h302) begin
                failures++;
                $display("FAIL hold_stable%0d: valid=%b bs=%b byte=%h want 1 1 02", k + 1, outValid, outBlockStart, outByte);
            end
            @(posedge clock); #2;
        end
        drain(ok);
        send_code(4'h8, 16'h0A0B, 7'd7);
        drain(ok);
        checks++;
        if (!ok || cap.size() != 12) begin
            failures++; $display("FAIL bp_len: got %0d bytes (drained=%0b) want 12", cap.size(), ok);
        end
        for (int k = 0; k < 12; k++) begin
            logic [8:0] got;
            got = (k < cap.size()) ? cap[k] : 9'hxxx;
            checks++;
            if (got !== exp_b[k]) begin
                failures++; $display("FAIL bp[%0d]: got %h want %h", k, got, exp_b[k]);
            end
        end
        cap.delete();
    endtask

    task automatic test_overflow;
        logic [8:0] exp_b [16] = '{9'h10B, 9'h00A, 9'h007, 9'h000, 9'h021, 9'h043,
                                   9'h10B, 9'h00A, 9'h007, 9'h000, 9'h065, 9'h087,
                                   9'h10B, 9'h00A, 9'h007, 9'h000};
        bit ok;
        outReady = 1'b0;
        for (int k = 0; k < 9; k++) send_code(4'(k + 1), 16'h0A0B, 7'd7);
        checks++;
        if ({overflow, holdOff} !== 2'b01) begin
            failures++; $display("FAIL full_no_ovf: ovf=%b hold=%b want 0 1", overflow, holdOff);
        end
        inPCM = 4'hA; inPcmValid = 1'b1;
        @(negedge clock);
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL ovf_early: got %b want 0", overflow);
        end
        @(posedge clock); #2;
        inPcmValid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_set: got %b want 1", overflow);
        end
        repeat (3) begin @(posedge clock); #2; end
        drain(ok);
        checks++;
        if (overflow !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky: got %b want 1", overflow);
        end
        checks++;
        if (!ok || cap.size() != 16) begin
            failures++; $display("FAIL ovf_len: got %0d bytes (drained=%0b) want 16", cap.size(), ok);
        end
        for (int k = 0; k < 16; k++) begin
            logic [8:0] got;
            got = (k < cap.size()) ? cap[k] : 9'hxxx;
            checks++;
            if (got !== exp_b[k]) begin
                failures++; $display("FAIL ovf[%0d]: got %h want %h", k, got, exp_b[k]);
            end
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (overflow !== 1'b0) begin
            failures++; $display("FAIL ovf_reset: got %b want 0", overflow);
        end
        @(posedge clock); #2;
        reset = 1'b0;
        cap.delete();
    endtask

    task automatic test_mid_block_reset;
        logic [8:0] exp_b [6] = '{9'h100, 9'h000, 9'h000, 9'h000, 9'h0ED, 9'h00F};
        bit ok;
        outReady = 1'b0;
        send_code(4'h1, 16'h7777, 7'd2);
        send_code(4'h2, 16'h7777, 7'd2);
        send_code(4'h3, 16'h7777, 7'd2);
        checks++;
        if (outValid !== 1'b1) begin
            failures++; $display("FAIL pre_reset_valid: got %b want 1", outValid);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (outValid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_valid: got %b want 0", outValid);
        end
        @(posedge clock); #2;
        reset = 1'b0;
        cap.delete();
        outReady = 1'b1;
        send_code(4'hD, 16'h5566, 7'd9);
        send_code(4'hE, 16'h5566, 7'd9);
        send_code(4'hF, 16'h5566, 7'd9);
        send_code(4'h0, 16'h5566, 7'd9);
        drain(ok);
        checks++;
        if (!ok || cap.size() != 6) begin
            failures++; $display("FAIL rst_block_len: got %0d bytes (drained=%0b) want 6", cap.size(), ok);
        end
        for (int k = 0; k < 6; k++) begin
            logic [8:0] got;
            got = (k < cap.size()) ? cap[k] : 9'hxxx;
            checks++;
            if (got !== exp_b[k]) begin
                failures++; $display("FAIL rst_block[%0d]: got %h want %h", k, got, exp_b[k]);
            end
        end
        cap.delete();
    endtask

    task automatic test_full_push_pop;
        logic [8:0] exp_b [17] = '{9'h166, 9'h055, 9'h009, 9'h000, 9'h021, 9'h043,
                                   9'h166, 9'h055, 9'h009, 9'h000, 9'h065, 9'h087,
                                   9'h166, 9'h055, 9'h009, 9'h000, 9'h0A9};
        bit ok;
        outReady = 1'b0;
        for (int k = 0; k < 9; k++) send_code(4'(k + 1), 16'h5566, 7'd9);
        inPCM = 4'hA; inPcmValid = 1'b1; outReady = 1'b1;
        @(posedge clock); #2;
        inPcmValid = 1'b0; outReady = 1'b0;
        checks++;
        if ({overflow, holdOff, outValid} !== 3'b011) begin
            failures++; $display("FAIL pushpop_full: ovf=%b hold=%b valid=%b want 0 1 1", overflow, holdOff, outValid);
        end
        checks++;
        if ({outBlockStart, outByte} !== 9'h055) begin
            failures++; $display("FAIL pushpop_head: got %h want 055", {outBlockStart, outByte});
        end
        repeat (3) begin @(posedge clock); #2; end
        drain(ok);
        checks++;
        if (!ok || cap.size() != 17) begin
            failures++; $display("FAIL pushpop_len: got %0d bytes (drained=%0b) want 17", cap.size(), ok);
        end
        for (int k = 0; k < 17; k++) begin
            logic [8:0] got;
            got = (k < cap.size()) ? cap[k] : 9'hxxx;
            checks++;
            if (got !== exp_b[k]) begin
                failures++; $display("FAIL pushpop[%0d]: got %h want %h", k, got, exp_b[k]);
            end
        end
        cap.delete();
    endtask

    initial begin
        test_reset();
        test_first_block();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_mid_block_reset();
        test_full_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
